// File: rtl/lif_neuron_array.sv
// Time-multiplexed leaky integrate-and-fire neuron array.
// Events accumulate per neuron, then one neuron is updated per cycle, and the spike vector is published.
module lif_neuron_array #(
  parameter int NUM_NEURONS  = 16,
  parameter int POTENT_WIDTH = 16,
  parameter int FRAC_BITS    = 8,
  parameter int REFRAC_LEN   = 5,
  parameter int POTENT_REST  = 0,
  parameter int POTENT_RESET = 0,
  parameter int THETA_INC    = 'h0010,
  parameter int INHIB_EN     = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   ev_valid,
  output logic                                   ev_ready,
  input  logic [$clog2(NUM_NEURONS)-1:0]         ev_nrn,
  input  logic signed [POTENT_WIDTH-1:0]         ev_weight,
  input  logic                                   ev_last,
  input  logic signed [POTENT_WIDTH-1:0]         leak_coef,
  input  logic signed [POTENT_WIDTH-1:0]         potent_thres,
  input  logic signed [POTENT_WIDTH-1:0]         inhib_weight,
  output logic [NUM_NEURONS-1:0]                 spike_out,
  output logic                                   spike_valid,
  output logic                                   drop_err
);

  // state    | meaning
  // S_ACCUM  | accept synaptic events into acc[]; wait one cycle after the last event
  // S_UPDATE | process neuron r_idx (leak, integrate, fire), one per cycle
  // S_OUT    | one-cycle spike_valid pulse, spike_out holds the new vector

  localparam int W     = POTENT_WIDTH;
  localparam int IDX_W = $clog2(NUM_NEURONS);
  localparam int XW    = 2 * W + 4;

  localparam logic signed [W-1:0]  C_REST      = W'(POTENT_REST);
  localparam logic signed [W-1:0]  C_RESET     = W'(POTENT_RESET);
  localparam logic signed [W-1:0]  C_THETA_INC = W'(THETA_INC);
  localparam logic [3:0]           C_REFRAC    = 4'(REFRAC_LEN);
  localparam logic signed [XW-1:0] SAT_MAX     = {{(XW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN     = {{(XW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_ACCUM, S_UPDATE, S_OUT} state_t;

  function automatic logic signed [XW-1:0] ext(input logic signed [W-1:0] a);
    return {{(XW-W){a[W-1]}}, a};
  endfunction

  function automatic logic signed [W-1:0] sat(input logic signed [XW-1:0] x);
    if (x > SAT_MAX)      return SAT_MAX[W-1:0];
    else if (x < SAT_MIN) return SAT_MIN[W-1:0];
    else                  return x[W-1:0];
  endfunction

  state_t r_state, w_state_nxt;

  logic                   r_alive;
  logic                   r_last_pend;
  logic                   r_drop_err;
  logic [IDX_W-1:0]       r_idx;
  logic [NUM_NEURONS-1:0] r_spk_acc;
  logic [NUM_NEURONS-1:0] r_spike_out;

  logic signed [W-1:0] r_v     [NUM_NEURONS];
  logic signed [W-1:0] r_acc   [NUM_NEURONS];
  logic signed [W-1:0] r_theta [NUM_NEURONS];
  logic [3:0]          r_refr  [NUM_NEURONS];

  logic                   w_accept;
  logic                   w_in_range;
  logic                   w_idx_last;
  logic signed [W-1:0]    w_acc_sel;
  logic signed [W-1:0]    w_acc_sum;
  logic signed [W-1:0]    w_v_cur, w_acc_cur, w_theta_cur;
  logic [3:0]             w_refr_cur;
  logic signed [XW-1:0]   w_diff, w_prod, w_base, w_sum;
  logic signed [W-1:0]    w_leak, w_vnew, w_thr, w_inh;
  logic signed [W-1:0]    w_theta_inc, w_theta_dec;
  logic                   w_spike;
  logic [NUM_NEURONS-1:0] w_spk_vec;

  // Power-of-two arrays cannot address a missing neuron, so the range check folds away.
  if ((1 << IDX_W) == NUM_NEURONS) begin : g_idx_full
    assign w_in_range = 1'b1;
  end else begin : g_idx_part
    assign w_in_range = (ev_nrn < IDX_W'(NUM_NEURONS));
  end

  assign w_accept   = ev_valid && ev_ready;
  assign w_idx_last = (r_idx == IDX_W'(NUM_NEURONS - 1));

  always_comb begin
    w_acc_sel = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (ev_nrn == IDX_W'(i)) w_acc_sel = r_acc[i];
    end
  end

  assign w_acc_sum = sat(ext(w_acc_sel) + ext(ev_weight));

  assign w_v_cur     = r_v[r_idx];
  assign w_acc_cur   = r_acc[r_idx];
  assign w_theta_cur = r_theta[r_idx];
  assign w_refr_cur  = r_refr[r_idx];

  // Full-width leak product, arithmetic shift floors toward minus infinity.
  assign w_diff = ext(w_v_cur) - ext(C_REST);
  assign w_prod = w_diff * ext(leak_coef);
  assign w_leak = sat(w_prod >>> FRAC_BITS);

  assign w_inh = ((INHIB_EN != 0) && (|r_spike_out) && !r_spike_out[r_idx]) ? inhib_weight : '0;

  assign w_base = ext(w_leak) + ext(C_REST);
  assign w_sum  = w_base + ext(w_acc_cur) + ext(w_inh);
  assign w_vnew = (w_refr_cur == 4'd0) ? sat(w_sum) : sat(w_base);

  assign w_thr       = sat(ext(potent_thres) + ext(w_theta_cur));
  assign w_spike     = (w_refr_cur == 4'd0) && (w_vnew >= w_thr);
  assign w_theta_inc = sat(ext(w_theta_cur) + ext(C_THETA_INC));
  assign w_theta_dec = w_theta_cur - (w_theta_cur >>> 4);

  always_comb begin
    w_spk_vec        = r_spk_acc;
    w_spk_vec[r_idx] = w_spike;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_ACCUM;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ACCUM:  if (r_last_pend) w_state_nxt = S_UPDATE;
      S_UPDATE: if (w_idx_last)  w_state_nxt = S_OUT;
      S_OUT:    w_state_nxt = S_ACCUM;
      default:  w_state_nxt = S_ACCUM;
    endcase
  end

  // Ready closes once the final event is in, so the step boundary stays clean.
  always_comb begin
    ev_ready    = 1'b0;
    spike_valid = 1'b0;
    case (r_state)
      S_ACCUM: ev_ready    = r_alive && !r_last_pend;
      S_OUT:   spike_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alive     <= 1'b0;
      r_last_pend <= 1'b0;
      r_drop_err  <= 1'b0;
      r_idx       <= '0;
      r_spk_acc   <= '0;
      r_spike_out <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_v[i]     <= C_REST;
        r_acc[i]   <= '0;
        r_theta[i] <= '0;
        r_refr[i]  <= '0;
      end
    end else begin
      r_alive <= 1'b1;
      if (w_accept) begin
        if (w_in_range) begin
          for (int i = 0; i < NUM_NEURONS; i++) begin
            if (ev_nrn == IDX_W'(i)) r_acc[i] <= w_acc_sum;
          end
        end else begin
          r_drop_err <= 1'b1;
        end
        if (ev_last) r_last_pend <= 1'b1;
      end
      if (r_state == S_ACCUM && r_last_pend) r_last_pend <= 1'b0;
      if (r_state == S_UPDATE) begin
        r_acc[r_idx] <= '0;
        r_spk_acc    <= w_spk_vec;
        if (w_spike) begin
          r_v[r_idx]     <= C_RESET;
          r_refr[r_idx]  <= C_REFRAC;
          r_theta[r_idx] <= w_theta_inc;
        end else begin
          r_v[r_idx]     <= w_vnew;
          r_theta[r_idx] <= w_theta_dec;
          if (w_refr_cur != 4'd0) r_refr[r_idx] <= w_refr_cur - 4'd1;
        end
        if (w_idx_last) begin
          r_idx       <= '0;
          r_spike_out <= w_spk_vec;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end
    end
  end

  assign spike_out = r_spike_out;
  assign drop_err  = r_drop_err;

endmodule
